// File: rtl/f_fetch_pkg.sv
// Shared constants and types for the fetch stage.
// Also holds the legal instruction-memory window used by the address checks.
package f_fetch_pkg;

   localparam logic [31:0] PC_RESET_DEF  = 32'h0000_3000;
   localparam logic [31:0] EXC_ENTRY_DEF = 32'h0000_4180;
   localparam logic [31:0] IM_BASE       = 32'h0000_3000;
   localparam logic [31:0] IM_TOP        = 32'h0000_6FFC;
   localparam logic [11:0] IM_INDEX_BASE = 12'hC00;

   typedef enum logic [2:0] {
      PC_EXC,
      PC_EPC,
      PC_HOLD,
      PC_REDIR,
      PC_SEQ
   } pc_sel_e;

   typedef enum logic {
      ST_RUN,
      ST_ERET_PEND
   } eret_st_e;

endpackage

// File: rtl/f_addr_check.sv
// Word-aligned window check on a 32-bit address.
// Window bounds are parameters so the data side can share this block.
module f_addr_check
   import f_fetch_pkg::*;
#(
   parameter logic [31:0] LO = IM_BASE,
   parameter logic [31:0] HI = IM_TOP
) (
   input  logic [31:0] addr,
   output logic        fault
);

   always_comb begin
      fault = (addr[1:0] != 2'b00) || (addr < LO) || (addr > HI);
   end

endmodule

// File: rtl/f_fetch_ctrl.sv
// Fetch-stage PC control: next-PC select, delay-slot flag, eret tracking.
// The instruction memory lives outside and is addressed by F_im_index.
module f_fetch_ctrl
   import f_fetch_pkg::*;
#(
   parameter logic [31:0] PC_RESET  = PC_RESET_DEF,
   parameter logic [31:0] EXC_ENTRY = EXC_ENTRY_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        F_stall,
   input  logic        D_redirect,
   input  logic [31:0] D_npc,
   input  logic        D_is_branch,
   input  logic        req,
   input  logic        eret,
   input  logic [31:0] EPC,
   input  logic [31:0] F_IM_instr,
   output logic [31:0] F_PC,
   output logic [11:0] F_im_index,
   output logic [31:0] F_instr,
   output logic        F_exc_adel,
   output logic        F_bd
);

   logic [31:0] pc_q, pc_d;
   logic        bd_q, bd_d;
   eret_st_e    st_q, st_d;
   pc_sel_e     sel;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q <= PC_RESET;
         bd_q <= 1'b0;
         st_q <= ST_RUN;
      end else begin
         pc_q <= pc_d;
         bd_q <= bd_d;
         st_q <= st_d;
      end
   end

   // A redirect seen right after eret belongs to the eret itself, not a branch.
   always_comb begin
      sel  = PC_SEQ;
      pc_d = pc_q + 32'd4;
      bd_d = D_is_branch;
      st_d = ST_RUN;
      if (req) begin
         sel  = PC_EXC;
         pc_d = EXC_ENTRY;
         bd_d = 1'b0;
      end else if (eret) begin
         sel  = PC_EPC;
         pc_d = EPC;
         bd_d = 1'b0;
         st_d = ST_ERET_PEND;
      end else if (F_stall) begin
         sel  = PC_HOLD;
         pc_d = pc_q;
         bd_d = bd_q;
      end else if (st_q == ST_ERET_PEND) begin
         sel  = PC_SEQ;
         pc_d = pc_q + 32'd4;
         bd_d = 1'b0;
      end else if (D_redirect) begin
         sel  = PC_REDIR;
         pc_d = D_npc;
      end
   end

   f_addr_check #(
      .LO (IM_BASE),
      .HI (IM_TOP)
   ) u_chk (
      .addr  (pc_q),
      .fault (F_exc_adel)
   );

   always_comb begin
      F_PC       = pc_q;
      F_bd       = bd_q;
      F_im_index = pc_q[13:2] - IM_INDEX_BASE;
      F_instr    = F_exc_adel ? 32'h0 : F_IM_instr;
   end

endmodule
